// File: rtl/vx_mem_responder.sv
// ---------------------------------------------------------------------------
// vx_mem_responder
//
// Memory endpoint for the cluster memory bus. It answers requests coming out
// of the L2 from a local line-wide RAM. Writes are absorbed with per-byte
// enables and produce no response. Reads are sampled in the accept cycle,
// travel through a LATENCY-deep pipeline and are then queued in an in-order
// response FIFO. A credit counter that covers the pipeline plus the FIFO
// throttles request acceptance, so the FIFO can never overflow.
//
// Ports:
//   clk, reset                        clock, asynchronous active-high reset
//   mem_req_valid / mem_req_ready     request handshake
//   mem_req_rw                        1 = write, 0 = read
//   mem_req_addr                      line address (low RAM_ADDR_WIDTH bits used)
//   mem_req_byteen, mem_req_data      write byte enables and write data
//   mem_req_tag                       request tag, echoed on the read response
//   mem_rsp_valid / mem_rsp_ready     read response handshake
//   mem_rsp_data, mem_rsp_tag         read data and originating tag
//   busy                              at least one read is outstanding
// ---------------------------------------------------------------------------
module vx_mem_responder #(
    parameter int DATA_SIZE      = 64,
    parameter int ADDR_WIDTH     = 26,
    parameter int TAG_WIDTH      = 8,
    parameter int RAM_ADDR_WIDTH = 10,
    parameter int LATENCY        = 4,
    parameter int RSP_QUEUE_SIZE = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mem_req_valid,
    input  logic                     mem_req_rw,
    input  logic [ADDR_WIDTH-1:0]    mem_req_addr,
    input  logic [DATA_SIZE-1:0]     mem_req_byteen,
    input  logic [DATA_SIZE*8-1:0]   mem_req_data,
    input  logic [TAG_WIDTH-1:0]     mem_req_tag,
    output logic                     mem_req_ready,
    output logic                     mem_rsp_valid,
    output logic [DATA_SIZE*8-1:0]   mem_rsp_data,
    output logic [TAG_WIDTH-1:0]     mem_rsp_tag,
    input  logic                     mem_rsp_ready,
    output logic                     busy
);

    localparam int DATA_WIDTH   = DATA_SIZE * 8;
    localparam int RAM_LINES    = 2 ** RAM_ADDR_WIDTH;
    localparam int PTR_WIDTH    = $clog2(RSP_QUEUE_SIZE);
    localparam int CREDIT_WIDTH = PTR_WIDTH + 1;
    localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(RSP_QUEUE_SIZE);

    logic [DATA_WIDTH-1:0]     ram [RAM_LINES];
    logic [RAM_ADDR_WIDTH-1:0] ram_index;

    logic                      write_fire;
    logic                      read_fire;
    logic                      rsp_fire;
    logic [CREDIT_WIDTH-1:0]   credits;

    logic                      pipe_valid [LATENCY];
    logic [DATA_WIDTH-1:0]     pipe_data  [LATENCY];
    logic [TAG_WIDTH-1:0]      pipe_tag   [LATENCY];

    logic [DATA_WIDTH-1:0]     fifo_data  [RSP_QUEUE_SIZE];
    logic [TAG_WIDTH-1:0]      fifo_tag   [RSP_QUEUE_SIZE];
    logic [PTR_WIDTH:0]        wr_ptr;
    logic [PTR_WIDTH:0]        rd_ptr;
    logic                      fifo_push;

    // Upper address bits are deliberately ignored so that addresses alias
    // modulo the RAM size.
    assign ram_index = mem_req_addr[RAM_ADDR_WIDTH-1:0];

    generate
        if (ADDR_WIDTH > RAM_ADDR_WIDTH) begin : g_alias
            logic unused_upper_addr;
            assign unused_upper_addr = ^mem_req_addr[ADDR_WIDTH-1:RAM_ADDR_WIDTH];
        end
    endgenerate

    // Credits are compared before they are updated, so a response fire frees
    // a slot that becomes visible on the following cycle.
    assign mem_req_ready = !reset && (credits < CREDIT_MAX);
    assign write_fire    = mem_req_valid && mem_req_ready && mem_req_rw;
    assign read_fire     = mem_req_valid && mem_req_ready && !mem_req_rw;

    assign fifo_push     = pipe_valid[LATENCY-1];
    assign mem_rsp_valid = (wr_ptr != rd_ptr);
    assign rsp_fire      = mem_rsp_valid && mem_rsp_ready;
    assign mem_rsp_data  = fifo_data[rd_ptr[PTR_WIDTH-1:0]];
    assign mem_rsp_tag   = fifo_tag[rd_ptr[PTR_WIDTH-1:0]];
    assign busy          = (credits != '0);

    // Line RAM write port. Contents are intentionally not reset; each byte
    // lane is updated only when its enable is set.
    always_ff @(posedge clk) begin
        if (write_fire) begin
            for (int i = 0; i < DATA_SIZE; i++) begin
                if (mem_req_byteen[i]) begin
                    ram[ram_index][i*8 +: 8] <= mem_req_data[i*8 +: 8];
                end
            end
        end
    end

    // Outstanding-read credits: one per accepted read, released when its
    // response is consumed. A simultaneous accept and release cancel out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credits <= '0;
        end else if (read_fire && !rsp_fire) begin
            credits <= credits + CREDIT_WIDTH'(1);
        end else if (!read_fire && rsp_fire) begin
            credits <= credits - CREDIT_WIDTH'(1);
        end
    end

    // Valid bits of the read pipeline. Reset discards everything in flight so
    // no stale response can surface after reset is released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_valid[i] <= 1'b0;
            end
        end else begin
            pipe_valid[0] <= read_fire;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
            end
        end
    end

    // Payload of the read pipeline. The RAM line is sampled in the accept
    // cycle, so a write accepted on an earlier edge is already visible. The
    // payload needs no reset because only the valid bits are qualified.
    always_ff @(posedge clk) begin
        pipe_data[0] <= ram[ram_index];
        pipe_tag[0]  <= mem_req_tag;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_data[i] <= pipe_data[i-1];
            pipe_tag[i]  <= pipe_tag[i-1];
        end
    end

    // Response FIFO pointers carry an extra wrap bit to tell full from empty.
    // The pipeline never stalls: credits guarantee there is always room.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr <= wr_ptr + (PTR_WIDTH+1)'(1);
            end
            if (rsp_fire) begin
                rd_ptr <= rd_ptr + (PTR_WIDTH+1)'(1);
            end
        end
    end

    // Response FIFO storage. The head entry is held until it is consumed, so
    // data and tag stay stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_data[wr_ptr[PTR_WIDTH-1:0]] <= pipe_data[LATENCY-1];
            fifo_tag[wr_ptr[PTR_WIDTH-1:0]]  <= pipe_tag[LATENCY-1];
        end
    end

endmodule

// File: tb/tb_vx_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_vx_mem_responder
//
// Self-checking bench for vx_mem_responder. The stimulus process issues
// directed requests and, for every tracked read it gets accepted, pushes the
// hand-computed response onto a scoreboard queue. A separate monitor pops the
// queue whenever a response handshake happens and compares data and tag.
// ---------------------------------------------------------------------------
module tb_vx_mem_responder;

    localparam int DATA_SIZE      = 64;
    localparam int ADDR_WIDTH     = 26;
    localparam int TAG_WIDTH      = 8;
    localparam int RAM_ADDR_WIDTH = 10;
    localparam int LATENCY        = 4;
    localparam int RSP_QUEUE_SIZE = 8;
    localparam int DATA_WIDTH     = DATA_SIZE * 8;

    typedef struct {
        logic [DATA_WIDTH-1:0] data;
        logic [TAG_WIDTH-1:0]  tag;
    } rsp_t;

    logic                    clk;
    logic                    reset;
    logic                    mem_req_valid;
    logic                    mem_req_rw;
    logic [ADDR_WIDTH-1:0]   mem_req_addr;
    logic [DATA_SIZE-1:0]    mem_req_byteen;
    logic [DATA_WIDTH-1:0]   mem_req_data;
    logic [TAG_WIDTH-1:0]    mem_req_tag;
    logic                    mem_req_ready;
    logic                    mem_rsp_valid;
    logic [DATA_WIDTH-1:0]   mem_rsp_data;
    logic [TAG_WIDTH-1:0]    mem_rsp_tag;
    logic                    mem_rsp_ready;
    logic                    busy;

    int   compared   = 0;
    int   mismatched = 0;
    rsp_t sb[$];

    vx_mem_responder #(
        .DATA_SIZE      (DATA_SIZE),
        .ADDR_WIDTH     (ADDR_WIDTH),
        .TAG_WIDTH      (TAG_WIDTH),
        .RAM_ADDR_WIDTH (RAM_ADDR_WIDTH),
        .LATENCY        (LATENCY),
        .RSP_QUEUE_SIZE (RSP_QUEUE_SIZE)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_req_valid  (mem_req_valid),
        .mem_req_rw     (mem_req_rw),
        .mem_req_addr   (mem_req_addr),
        .mem_req_byteen (mem_req_byteen),
        .mem_req_data   (mem_req_data),
        .mem_req_tag    (mem_req_tag),
        .mem_req_ready  (mem_req_ready),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .mem_rsp_tag    (mem_rsp_tag),
        .mem_rsp_ready  (mem_rsp_ready),
        .busy           (busy)
    );

    // 10 ns clock; inputs change 1 ns after the rising edge, outputs are
    // sampled on the falling edge.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net in case a handshake never completes.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [DATA_WIDTH-1:0] lineOf(input logic [7:0] b);
        return {DATA_SIZE{b}};
    endfunction

    task automatic checkOutput(input string name, input logic [DATA_WIDTH-1:0] actual,
                               input logic [DATA_WIDTH-1:0] required);
        compared++;
        if (actual !== required) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, required);
        end
    endtask

    // Waits (bounded) for mem_req_ready with the request already driven, then
    // lets the accepting edge pass and drops valid. Leaves time at edge + 1.
    task automatic waitAccept(input string name, output bit ok);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!mem_req_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!mem_req_ready) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s: request not accepted within 200 cycles, ready=%0b", name, mem_req_ready);
            ok = 1'b0;
            @(posedge clk);
            #1;
            mem_req_valid = 1'b0;
        end else begin
            ok = 1'b1;
            @(posedge clk);
            #1;
            mem_req_valid = 1'b0;
        end
    endtask

    // For writes, line is the write data. For reads, line is the expected
    // response data, pushed to the scoreboard on acceptance when track is set.
    task automatic applyStimulus(input string name, input logic rw,
                                 input logic [ADDR_WIDTH-1:0] addr,
                                 input logic [DATA_SIZE-1:0] byteen,
                                 input logic [DATA_WIDTH-1:0] line,
                                 input logic [TAG_WIDTH-1:0] tag,
                                 input bit track, output bit ok);
        rsp_t e;
        mem_req_valid  = 1'b1;
        mem_req_rw     = rw;
        mem_req_addr   = addr;
        mem_req_byteen = byteen;
        mem_req_data   = rw ? line : '0;
        mem_req_tag    = tag;
        waitAccept(name, ok);
        if (ok && !rw && track) begin
            e.data = line;
            e.tag  = tag;
            sb.push_back(e);
        end
    endtask

    // Bounded wait until every expected response has been consumed.
    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s: %0d responses still pending, expected 0", name, sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Response monitor: compares each consumed response against the head of
    // the scoreboard. Any response with nothing expected is an error.
    always @(negedge clk) begin
        rsp_t e;
        if (!reset && mem_rsp_valid && mem_rsp_ready) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_rsp: got tag %0h, expected no response", mem_rsp_tag);
            end else begin
                e = sb.pop_front();
                checkOutput("rsp_tag", DATA_WIDTH'(mem_rsp_tag), DATA_WIDTH'(e.tag));
                checkOutput("rsp_data", mem_rsp_data, e.data);
            end
        end
    end

    initial begin
        bit ok;
        int n;
        int accepted;
        int stale;
        rsp_t e;

        reset          = 1'b1;
        mem_req_valid  = 1'b0;
        mem_req_rw     = 1'b0;
        mem_req_addr   = '0;
        mem_req_byteen = '0;
        mem_req_data   = '0;
        mem_req_tag    = '0;
        mem_rsp_ready  = 1'b0;

        // Reset state
        @(negedge clk);
        checkOutput("rst_req_ready", DATA_WIDTH'(mem_req_ready), '0);
        checkOutput("rst_rsp_valid", DATA_WIDTH'(mem_rsp_valid), '0);
        checkOutput("rst_busy", DATA_WIDTH'(busy), '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_ready", DATA_WIDTH'(mem_req_ready), DATA_WIDTH'(1));
        @(posedge clk);
        #1;

        // Write then read on the next edge, checking read latency
        mem_rsp_ready = 1'b1;
        applyStimulus("wr_a5", 1'b1, 26'h5, '1, lineOf(8'hA5), 8'h00, 1'b0, ok);
        applyStimulus("rd_a5", 1'b0, 26'h5, '0, lineOf(8'hA5), 8'h3C, 1'b1, ok);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_rsp_valid && n < 50);
        checkOutput("read_latency", DATA_WIDTH'(n), DATA_WIDTH'(LATENCY + 1));
        waitDrain("drain_a5");

        // Partial byte-enable write
        applyStimulus("wr_zero", 1'b1, 26'h7, '1, lineOf(8'h00), 8'h00, 1'b0, ok);
        applyStimulus("wr_byte0", 1'b1, 26'h7, 64'h1, lineOf(8'hFF), 8'h00, 1'b0, ok);
        applyStimulus("rd_byte0", 1'b0, 26'h7, '0, {{(DATA_SIZE-1){8'h00}}, 8'hFF}, 8'h21, 1'b1, ok);
        waitDrain("drain_byte0");

        // Preload lines 0x20..0x29 for the backpressure test
        for (int i = 0; i < 10; i++) begin
            applyStimulus("wr_stream", 1'b1, ADDR_WIDTH'(32'h20 + i), '1,
                          lineOf(8'(8'h40 + i)), 8'h00, 1'b0, ok);
        end

        // Backpressure: with the consumer stalled only 8 reads fit
        mem_rsp_ready = 1'b0;
        accepted = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus("rd_stream", 1'b0, ADDR_WIDTH'(32'h20 + i), '0,
                          lineOf(8'(8'h40 + i)), 8'(i), 1'b1, ok);
            if (ok) accepted++;
        end
        checkOutput("stream_accepted", DATA_WIDTH'(accepted), DATA_WIDTH'(8));
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b0;
        mem_req_addr  = 26'h28;
        mem_req_tag   = 8'd8;
        @(negedge clk);
        checkOutput("full_ready", DATA_WIDTH'(mem_req_ready), '0);
        checkOutput("full_busy", DATA_WIDTH'(busy), DATA_WIDTH'(1));
        checkOutput("full_rsp_valid", DATA_WIDTH'(mem_rsp_valid), DATA_WIDTH'(1));

        // Single response fire while read 8 is pending at full credits
        @(posedge clk);
        #1;
        mem_rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("full_ready_held", DATA_WIDTH'(mem_req_ready), '0);
        @(posedge clk);
        #1;
        mem_rsp_ready = 1'b0;
        @(negedge clk);
        checkOutput("reopen_ready", DATA_WIDTH'(mem_req_ready), DATA_WIDTH'(1));
        e.data = lineOf(8'h48);
        e.tag  = 8'd8;
        sb.push_back(e);
        @(posedge clk);
        #1;
        mem_req_valid = 1'b0;
        @(negedge clk);
        checkOutput("refill_ready", DATA_WIDTH'(mem_req_ready), '0);
        checkOutput("refill_busy", DATA_WIDTH'(busy), DATA_WIDTH'(1));
        @(posedge clk);
        #1;

        // Release the consumer; tag 9 then gets in and everything drains
        mem_rsp_ready = 1'b1;
        applyStimulus("rd_tag9", 1'b0, 26'h29, '0, lineOf(8'h49), 8'd9, 1'b1, ok);
        waitDrain("drain_stream");
        checkOutput("drain_busy", DATA_WIDTH'(busy), '0);

        // Reset with reads in flight: nothing may come out afterwards
        for (int i = 0; i < 3; i++) begin
            applyStimulus("rd_flush", 1'b0, 26'h5, '0, lineOf(8'hA5), 8'(8'h50 + i), 1'b0, ok);
        end
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_valid", DATA_WIDTH'(mem_rsp_valid), '0);
        checkOutput("mid_rst_busy", DATA_WIDTH'(busy), '0);
        checkOutput("mid_rst_ready", DATA_WIDTH'(mem_req_ready), '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        stale = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (mem_rsp_valid) stale++;
        end
        checkOutput("stale_rsp_cycles", DATA_WIDTH'(stale), '0);
        checkOutput("post_flush_busy", DATA_WIDTH'(busy), '0);
        @(posedge clk);
        #1;
        applyStimulus("rd_after_rst", 1'b0, 26'h5, '0, lineOf(8'hA5), 8'h11, 1'b1, ok);
        waitDrain("drain_after_rst");

        // Address aliasing modulo the RAM size
        applyStimulus("wr_alias", 1'b1, 26'h405, '1, lineOf(8'h3E), 8'h00, 1'b0, ok);
        applyStimulus("rd_alias", 1'b0, 26'h005, '0, lineOf(8'h3E), 8'h77, 1'b1, ok);
        waitDrain("drain_alias");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
